fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of decode. Holds the fetch PC and issues word requests to an in-order instruction memory with a request/response handshake. Tags each request with its PC and buffers returned instructions in a small FIFO. Presents {valid, pc, instr} to decode, which consumes an entry whenever it is not stalling. On flush it redirects, discards in-flight responses and empties the buffer.

---
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: holds the fetch PC, issues PC-tagged word requests and buffers returned instructions for decode.
// Latency: request combinational from fetch_pc; a response is visible to decode the cycle after it returns.
// Backpressure: issue waits for outstanding/buffer headroom; decode stall holds the head; flush discards in-flight work.
// Optional build macro FETCH_ERR_EN adds i_imem_rsp_err / o_if_fault and blocks issue after a buffered error.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
`ifdef FETCH_ERR_EN
  input  logic        i_imem_rsp_err,
  output logic        o_if_fault,
`endif
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int BAW = $clog2(FIFO_DEPTH);
`ifdef FETCH_ERR_EN
  localparam int PW  = 65;
`else
  localparam int PW  = 64;
`endif

  logic [31:0]    fetch_pc;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  drop_cnt;

  // PC tag queue: one entry per live (non-dropped) request
  logic [31:0]    tag_mem [MAX_OUTSTANDING];
  logic [TAW-1:0] tag_wr;
  logic [TAW-1:0] tag_rd;
  logic [OW-1:0]  tag_count;

  // instruction buffer: {fault?, pc, instr}
  logic [PW-1:0]  buf_mem [FIFO_DEPTH];
  logic [BAW-1:0] buf_wr;
  logic [BAW-1:0] buf_rd;
  logic [FCW-1:0] fifo_count;
  logic [PW-1:0]  buf_head;
  logic [PW-1:0]  buf_push_dat;

  logic           issue_ok;
  logic           accept;
  logic           rsp_live;
  logic           rsp_keep;
  logic           consume;
  logic           buf_nonempty;
  logic [31:0]    in_flight_sum;
`ifdef FETCH_ERR_EN
  logic           err_hold;
`endif

  // issue gate: live responses plus buffered entries must never exceed buffer space
  always_comb begin
    in_flight_sum = 32'(outstanding) - 32'(drop_cnt) + 32'(fifo_count);
    issue_ok = rst_n && !i_flush
               && (outstanding < OW'(MAX_OUTSTANDING))
               && (in_flight_sum < 32'(FIFO_DEPTH));
`ifdef FETCH_ERR_EN
    issue_ok = issue_ok && !err_hold;
`endif
  end

  assign o_imem_req_valid = issue_ok;
  assign o_imem_req_addr  = fetch_pc;
  assign accept           = issue_ok && i_imem_req_ready;
  // a response with nothing outstanding is a protocol error and is ignored
  assign rsp_live         = i_imem_rsp_valid && (outstanding != '0);
  assign rsp_keep         = rsp_live && (drop_cnt == '0) && !i_flush;
  assign buf_nonempty     = (fifo_count != '0);
  assign o_if_valid       = buf_nonempty && !i_flush;
  assign consume          = o_if_valid && !i_stall;

  // fetch PC, outstanding count and stale-response drop count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (i_flush)
        fetch_pc <= i_redirect_pc & 32'hFFFF_FFFC;
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;

      case ({accept, rsp_live})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      // everything still in flight after this cycle's response belongs to the old stream
      if (i_flush)
        drop_cnt <= rsp_live ? (outstanding - OW'(1)) : outstanding;
      else if (rsp_live && (drop_cnt != '0))
        drop_cnt <= drop_cnt - OW'(1);
    end
  end

  // tag queue pointers: push on accept, pop on every kept response, clear on flush
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      tag_wr    <= '0;
      tag_rd    <= '0;
      tag_count <= '0;
    end else begin
      if (accept)
        tag_wr <= (tag_wr == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + TAW'(1);
      if (rsp_keep)
        tag_rd <= (tag_rd == TAW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + TAW'(1);
      case ({accept, rsp_keep})
        2'b10:   tag_count <= tag_count + OW'(1);
        2'b01:   tag_count <= tag_count - OW'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  // tag storage write
  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[tag_wr] <= fetch_pc;
  end

`ifdef FETCH_ERR_EN
  assign buf_push_dat = {i_imem_rsp_err, tag_mem[tag_rd], i_imem_rsp_data};
`else
  assign buf_push_dat = {tag_mem[tag_rd], i_imem_rsp_data};
`endif

  // instruction buffer pointers: push on kept response, pop on consume, clear on flush
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      buf_wr     <= '0;
      buf_rd     <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_keep)
        buf_wr <= buf_wr + BAW'(1);
      if (consume)
        buf_rd <= buf_rd + BAW'(1);
      case ({rsp_keep, consume})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // instruction buffer storage write
  always_ff @(posedge clk) begin
    if (rsp_keep)
      buf_mem[buf_wr] <= buf_push_dat;
  end

  assign buf_head   = buf_mem[buf_rd];
  assign o_if_pc    = buf_nonempty ? buf_head[63:32] : 32'h0;
  assign o_if_instr = buf_nonempty ? buf_head[31:0]  : 32'h0;

`ifdef FETCH_ERR_EN
  assign o_if_fault = buf_nonempty ? buf_head[64] : 1'b0;

  // once a faulting fetch is buffered, stop fetching down that path until redirected
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush)
      err_hold <= 1'b0;
    else if (rsp_keep && i_imem_rsp_err)
      err_hold <= 1'b1;
  end
`endif

  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_imem_rsp_valid && (outstanding == '0)));

  a_tag_tracking: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(tag_count) + 32'(drop_cnt)) == 32'(outstanding));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test of fetch_stage against a 1-cycle in-order instruction memory.
// Memory returns addr ^ 32'hA5A5_0000; responses can be held back to build up outstanding requests.
// All expected values are hand-computed per step.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
`ifdef FETCH_ERR_EN
  logic        i_imem_rsp_err;
  logic        o_if_fault;
  logic [31:0] err_addr;
`endif
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;

  int          total = 0;
  int          bad   = 0;
  logic        mem_en;
  logic [31:0] pend [$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall          (i_stall),
    .i_flush          (i_flush),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
`ifdef FETCH_ERR_EN
    .i_imem_rsp_err   (i_imem_rsp_err),
    .o_if_fault       (o_if_fault),
`endif
    .o_if_valid       (o_if_valid),
    .o_if_pc          (o_if_pc),
    .o_if_instr       (o_if_instr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: note any accept before the edge, then drive the next memory response
  task automatic step();
    logic        acc;
    logic [31:0] a;
    logic [31:0] ra;
    #1;
    acc = o_imem_req_valid && i_imem_req_ready;
    a   = o_imem_req_addr;
    @(posedge clk);
    #1;
    if (acc)
      pend.push_back(a);
    if (mem_en && (pend.size() != 0)) begin
      ra = pend.pop_front();
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = ra ^ K;
`ifdef FETCH_ERR_EN
      i_imem_rsp_err   = (ra == err_addr);
`endif
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = 32'h0;
`ifdef FETCH_ERR_EN
      i_imem_rsp_err   = 1'b0;
`endif
    end
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    i_stall          = 1'b0;
    i_flush          = 1'b0;
    i_redirect_pc    = 32'h0;
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = 32'h0;
    mem_en           = 1'b1;
`ifdef FETCH_ERR_EN
    i_imem_rsp_err   = 1'b0;
    err_addr         = 32'h0000_0001;
`endif

    // reset
    step();
    step();
    check("rst_req_vld",  32'(o_imem_req_valid), 32'd0);
    check("rst_if_vld",   32'(o_if_valid),       32'd0);
    check("rst_if_pc",    o_if_pc,               32'h0);
    check("rst_if_instr", o_if_instr,            32'h0);
    check("rst_req_addr", o_imem_req_addr,       32'h0);
    rst_n = 1'b1;
    #1;
    check("first_req_vld",  32'(o_imem_req_valid), 32'd1);
    check("first_req_addr", o_imem_req_addr,       32'h0);

    // streaming fetch
    step();
    check("e1_req_addr", o_imem_req_addr,       32'h4);
    check("e1_if_vld",   32'(o_if_valid),       32'd0);
    step();
    check("e2_if_vld",   32'(o_if_valid),       32'd1);
    check("e2_if_pc",    o_if_pc,               32'h0);
    check("e2_if_instr", o_if_instr,            32'hA5A5_0000);
    check("e2_req_vld",  32'(o_imem_req_valid), 32'd0);
    step();
    check("e3_if_pc",    o_if_pc,               32'h4);
    check("e3_if_instr", o_if_instr,            32'hA5A5_0004);
    check("e3_req_addr", o_imem_req_addr,       32'h8);

    // decode stall: buffer fills to two entries, issue stops, head holds
    i_stall = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      check("stall_hold_pc", o_if_pc, 32'h4);
    end
    check("stall_req_vld", 32'(o_imem_req_valid), 32'd0);
    check("stall_if_vld",  32'(o_if_valid),       32'd1);
    i_stall = 1'b0;
    step();
    check("rel_if_pc",    o_if_pc,         32'h8);
    check("rel_if_instr", o_if_instr,      32'hA5A5_0008);
    check("rel_req_addr", o_imem_req_addr, 32'hC);
    step();
    check("rel2_if_vld",   32'(o_if_valid), 32'd0);
    check("rel2_req_addr", o_imem_req_addr, 32'h10);

    // hold memory responses to get two requests outstanding
    mem_en = 1'b0;
    step();
    check("hold_if_pc",   o_if_pc,               32'hC);
    check("hold_req_vld", 32'(o_imem_req_valid), 32'd0);
    step();
    check("hold2_req_addr", o_imem_req_addr, 32'h14);
    step();
    check("two_out_req_vld", 32'(o_imem_req_valid), 32'd0);

    // flush to 0x1000 with 0x10 and 0x14 in flight
    i_flush = 1'b1;
    i_redirect_pc = 32'h1000;
    mem_en = 1'b1;
    #1;
    check("flush_req_vld", 32'(o_imem_req_valid), 32'd0);
    check("flush_if_vld",  32'(o_if_valid),       32'd0);
    step();
    i_flush = 1'b0;
    #1;
    check("postflush_req_vld", 32'(o_imem_req_valid), 32'd0);
    step();
    check("redir_req_addr", o_imem_req_addr,       32'h1000);
    check("redir_req_vld",  32'(o_imem_req_valid), 32'd1);
    step();
    check("stale_dropped_if_vld", 32'(o_if_valid), 32'd0);
    check("redir2_req_addr",      o_imem_req_addr, 32'h1004);
    step();
    check("redir_if_pc",    o_if_pc,    32'h1000);
    check("redir_if_instr", o_if_instr, 32'hA5A5_1000);

    // misaligned redirect is word-aligned
    i_flush = 1'b1;
    i_redirect_pc = 32'h2003;
    step();
    i_flush = 1'b0;
    #1;
    check("align_req_addr", o_imem_req_addr, 32'h2000);
    check("align_if_vld",   32'(o_if_valid), 32'd0);
    check("align_if_pc",    o_if_pc,         32'h0);

    // PC wrap at the top of the address space
    i_flush = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    step();
    i_flush = 1'b0;
    #1;
    check("wrap_req_addr0", o_imem_req_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_req_addr1", o_imem_req_addr,       32'h0);
    check("wrap_req_vld",   32'(o_imem_req_valid), 32'd1);
    step();
    check("wrap_if_pc0",    o_if_pc,    32'hFFFF_FFFC);
    check("wrap_if_instr0", o_if_instr, 32'h5A5A_FFFC);
    step();
    check("wrap_if_pc1",    o_if_pc,    32'h0);
    check("wrap_if_instr1", o_if_instr, 32'hA5A5_0000);

    // flush wins over stall: buffered entry is discarded
    i_stall = 1'b1;
    i_flush = 1'b1;
    i_redirect_pc = 32'h300;
    #1;
    check("fs_if_vld", 32'(o_if_valid), 32'd0);
    step();
    i_flush = 1'b0;
    #1;
    check("fs_cleared_if_vld", 32'(o_if_valid), 32'd0);
    check("fs_req_addr",       o_imem_req_addr, 32'h300);
    i_stall = 1'b0;

`ifdef FETCH_ERR_EN
    // error response for 0x10 halts issue until the next flush
    err_addr = 32'h10;
    i_flush = 1'b1;
    i_redirect_pc = 32'h10;
    step();
    i_flush = 1'b0;
    #1;
    check("err_req_addr0", o_imem_req_addr, 32'h10);
    step();
    check("err_req_addr1", o_imem_req_addr, 32'h14);
    step();
    check("err_fault",   32'(o_if_fault),       32'd1);
    check("err_if_pc",   o_if_pc,               32'h10);
    check("err_req_vld", 32'(o_imem_req_valid), 32'd0);
    step();
    check("err_next_fault", 32'(o_if_fault),       32'd0);
    check("err_next_pc",    o_if_pc,               32'h14);
    check("err_blocked",    32'(o_imem_req_valid), 32'd0);
    step();
    check("err_empty_vld",   32'(o_if_valid),       32'd0);
    check("err_blocked2",    32'(o_imem_req_valid), 32'd0);
    i_flush = 1'b1;
    i_redirect_pc = 32'h40;
    step();
    i_flush = 1'b0;
    #1;
    check("err_resume_vld",  32'(o_imem_req_valid), 32'd1);
    check("err_resume_addr", o_imem_req_addr,       32'h40);
    step();
    step();
    check("err_resume_pc",    o_if_pc,          32'h40);
    check("err_resume_instr", o_if_instr,       32'hA5A5_0040);
    check("err_resume_fault", 32'(o_if_fault),  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
